// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the width limit.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, one bit per clock through one full-subtractor cell.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // A request is taken whenever no operation is in flight, including the done cycle.
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (state_q == S_RUN) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    br_d   = br_q;
    diff_d = diff_q;
    bout_d = bout_q;
    if (accept) begin
      sa_d   = a;
      sb_d   = b;
      br_d   = 1'b0;
      cnt_d  = '0;
      diff_d = '0;
      bout_d = 1'b0;
    end else if (state_q == S_RUN) begin
      sa_d   = sa_q >> 1;
      sb_d   = sb_q >> 1;
      br_d   = cell_bout;
      cnt_d  = cnt_q + CNT_W'(1);
      // New result bit enters at the MSB so the word is aligned after WIDTH shifts.
      diff_d = (diff_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
      if (last_bit) bout_d = cell_bout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the last bit the shift registers hold the operand sign bits.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (last_bit) begin
      ovf_d = (sa_q[0] != sb_q[0]) && (cell_d != sa_q[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8); ovf checks build with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] exp_d, input logic exp_b);
    int busy_n;
    bit seen;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, busy_n, WIDTH);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(bout), 32'(exp_b));
  endtask

  initial begin
    bit             seen;
    int             done_n;
    logic [7:0]     ra, rb;
    logic [8:0]     exp_r;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic operations and boundaries
    run_op("t100m37", 8'd100, 8'd37, 8'd63, 1'b0);
    @(negedge clk);
    check("hold_done", 32'(done), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_diff", 32'(diff), 32'd63);
    run_op("t5m9", 8'd5, 8'd9, 8'hFC, 1'b1);
    run_op("t0m0", 8'd0, 8'd0, 8'd0, 1'b0);
    run_op("t255m255", 8'd255, 8'd255, 8'd0, 1'b0);
    run_op("t0m1", 8'd0, 8'd1, 8'hFF, 1'b1);
    run_op("t255m0", 8'd255, 8'd0, 8'hFF, 1'b0);

    // Start during RUN is ignored; start on the done cycle is accepted
    @(negedge clk);
    a = 8'd100;
    b = 8'd37;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    wait_done(seen);
    check("ign_done", 32'(seen), 32'd1);
    check("ign_diff", 32'(diff), 32'd63);
    check("ign_bout", 32'(bout), 32'd0);
    a = 8'd5;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    check("b2b_diff_cleared", 32'(diff), 32'd0);
    wait_done(seen);
    check("b2b_seen", 32'(seen), 32'd1);
    check("b2b_diff", 32'(diff), 32'hFC);
    check("b2b_bout", 32'(bout), 32'd1);

    // Asynchronous reset in the middle of a RUN
    @(negedge clk);
    a = 8'd100;
    b = 8'd37;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_diff_partial", 32'(diff), 32'hF0);
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("mid_no_done", done_n, 0);
    run_op("t10m3", 8'd10, 8'd3, 8'd7, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1);
    check("ovf_7f_ff_ovf", 32'(ovf), 32'd1);
    run_op("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("ovf_80_01_ovf", 32'(ovf), 32'd1);
    run_op("ovf_10_01", 8'h10, 8'h01, 8'h0F, 1'b0);
    check("ovf_10_01_ovf", 32'(ovf), 32'd0);
`endif

    // Random operands, mixing back-to-back and spaced requests
    @(negedge clk);
    ra = 8'($urandom);
    rb = 8'($urandom);
    a = ra;
    b = rb;
    start = 1'b1;
    exp_r = {1'b0, ra} - {1'b0, rb};
    for (int k = 0; k < 500; k++) begin
      wait_done(seen);
      check("rnd_done", 32'(seen), 32'd1);
      check("rnd_result", 32'({bout, diff}), 32'(exp_r));
      if (!seen) break;
      if (k < 499) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if ($urandom_range(0, 1) == 0) @(negedge clk);
        a = ra;
        b = rb;
        start = 1'b1;
        exp_r = {1'b0, ra} - {1'b0, rb};
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
